// File: rtl/mmio_regbank_v2.sv
// -----------------------------------------------------------------------------
// mmio_regbank_v2
//   CPU-visible register file sitting between a PicoRV32-style MMI bus and the
//   peripheral blocks. Addresses 0..NSTAT-1 are status registers loaded by the
//   peripherals (read-only from the CPU, each with a read-to-clear pending bit
//   feeding a maskable level interrupt). Addresses NSTAT..NREG-1 are control
//   registers written by the CPU under byte strobes, each producing a one-cycle
//   pulse after a write. Addresses at or above NREG read as zero and ignore
//   writes. The bus acknowledge arrives RD_LAT cycles after the request is
//   accepted.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous reset, active low
//   mmi_valid     bus request, held until mmi_ready
//   mmi_wstrb     byte write strobes (all zero = read)
//   mmi_ready     one-cycle transaction acknowledge
//   i_mmi_wdata   write data
//   o_mmi_rdata   read data, valid while mmi_ready is high
//   i_mmi_addr    register address
//   i_stat        peripheral status data, slice k -> register k
//   i_stat_we     per-status-register load enable
//   o_ctrl        control register contents, slice j -> register NSTAT+j
//   o_ctrl_pulse  one-cycle pulse after a CPU write to control register j
//   o_irq         level interrupt, |(pending & IRQ_MASK) delayed one cycle
// -----------------------------------------------------------------------------
module mmio_regbank_v2 #(
  parameter int unsigned       DW       = 32,
  parameter int unsigned       AW       = 3,
  parameter int unsigned       NREG     = 8,
  parameter int unsigned       NSTAT    = 3,
  parameter int unsigned       RD_LAT   = 1,
  parameter logic [NSTAT-1:0]  IRQ_MASK = {NSTAT{1'b1}}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mmi_valid,
  input  logic [DW/8-1:0]             mmi_wstrb,
  output logic                        mmi_ready,
  input  logic [DW-1:0]               i_mmi_wdata,
  output logic [DW-1:0]               o_mmi_rdata,
  input  logic [AW-1:0]               i_mmi_addr,
  input  logic [NSTAT*DW-1:0]         i_stat,
  input  logic [NSTAT-1:0]            i_stat_we,
  output logic [(NREG-NSTAT)*DW-1:0]  o_ctrl,
  output logic [NREG-NSTAT-1:0]       o_ctrl_pulse,
  output logic                        o_irq
);

  localparam int unsigned NCTRL = NREG - NSTAT;
  localparam int unsigned NB    = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              is_rd_q, is_rd_d;

  logic [DW-1:0]     stat_q [NSTAT];
  logic [DW-1:0]     stat_d [NSTAT];
  logic [DW-1:0]     ctrl_q [NCTRL];
  logic [DW-1:0]     ctrl_d [NCTRL];
  logic [NSTAT-1:0]  pend_q, pend_d;
  logic [NCTRL-1:0]  pulse_q, pulse_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              irq_q, irq_d;

  logic              accept;
  logic              req_wr;
  logic              enter_resp;
  logic [AW-1:0]     rd_addr;
  logic              rd_kind;
  logic [DW-1:0]     rd_val;

  assign accept     = (state_q == S_IDLE) && mmi_valid;
  assign req_wr     = |mmi_wstrb;
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // With RD_LAT=1 the RESP-entry edge is the accept edge itself, so the read
  // address/kind must come straight from the bus rather than the latches.
  assign rd_addr = (state_q == S_IDLE) ? i_mmi_addr : addr_q;
  assign rd_kind = (state_q == S_IDLE) ? ~req_wr    : is_rd_q;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    is_rd_d = is_rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (mmi_valid) begin
          addr_d  = i_mmi_addr;
          is_rd_d = ~req_wr;
          if (RD_LAT <= 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(RD_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file next state
  // ---------------------------------------------------------------------------
  always_comb begin
    stat_d  = stat_q;
    ctrl_d  = ctrl_q;
    pend_d  = pend_q;
    pulse_d = '0;
    rdata_d = rdata_q;
    irq_d   = |(pend_q & IRQ_MASK);

    // Clear-on-read is applied before the load so a same-edge load wins.
    for (int unsigned k = 0; k < NSTAT; k++) begin
      if (accept && !req_wr && (i_mmi_addr == AW'(k))) begin
        pend_d[k] = 1'b0;
      end
      if (i_stat_we[k]) begin
        stat_d[k] = i_stat[k*DW +: DW];
        pend_d[k] = 1'b1;
      end
    end

    for (int unsigned j = 0; j < NCTRL; j++) begin
      if (accept && req_wr && (i_mmi_addr == AW'(NSTAT + j))) begin
        pulse_d[j] = 1'b1;
        for (int unsigned b = 0; b < NB; b++) begin
          if (mmi_wstrb[b]) begin
            ctrl_d[j][b*8 +: 8] = i_mmi_wdata[b*8 +: 8];
          end
        end
      end
    end

    if (enter_resp && rd_kind) begin
      rdata_d = rd_val;
    end
  end

  // Full-width address match: anything not decoded reads as zero.
  always_comb begin
    rd_val = '0;
    for (int unsigned k = 0; k < NSTAT; k++) begin
      if (rd_addr == AW'(k)) begin
        rd_val = stat_q[k];
      end
    end
    for (int unsigned j = 0; j < NCTRL; j++) begin
      if (rd_addr == AW'(NSTAT + j)) begin
        rd_val = ctrl_q[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      is_rd_q <= 1'b0;
      stat_q  <= '{default: '0};
      ctrl_q  <= '{default: '0};
      pend_q  <= '0;
      pulse_q <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      is_rd_q <= is_rd_d;
      stat_q  <= stat_d;
      ctrl_q  <= ctrl_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mmi_ready    = (state_q == S_RESP);
  assign o_mmi_rdata  = rdata_q;
  assign o_ctrl_pulse = pulse_q;
  assign o_irq        = irq_q;

  for (genvar j = 0; j < NCTRL; j++) begin : g_ctrl
    assign o_ctrl[j*DW +: DW] = ctrl_q[j];
  end

endmodule
